// File: rtl/fifo_access_arbiter_if.sv
// Bus between the FIFO access arbiter, its requesters and the shared FIFO.
// The arbiter takes the slave modport; the requesters and FIFO side take master.
interface fifo_access_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            WrReq;
  logic [DATA_WIDTH-1:0] WrData0;
  logic [DATA_WIDTH-1:0] WrData1;
  logic [1:0]            WrGnt;
  logic [1:0]            RdReq;
  logic [1:0]            RdGnt;
  logic [1:0]            RdValid;
  logic [DATA_WIDTH-1:0] RdData;
  logic [1:0]            Opcode;
  logic [DATA_WIDTH-1:0] Din;
  logic [DATA_WIDTH-1:0] FifoDout;
  logic [3:0]            Level;

  modport slave (
    input  WrReq, WrData0, WrData1, RdReq, FifoDout,
    output WrGnt, RdGnt, RdValid, RdData, Opcode, Din, Level
  );

  modport master (
    output WrReq, WrData0, WrData1, RdReq, FifoDout,
    input  WrGnt, RdGnt, RdValid, RdData, Opcode, Din, Level
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// Arbiter sharing one FIFO between two writers and two readers.
// One operation per cycle, registered FIFO command outputs, a shadow
// occupancy count instead of the FIFO flags, and a two-stage reader tag
// pipeline that routes returning FIFO data to the granted reader.
module fifo_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEVEL  = 15
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  fifo_access_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10
  } state_t;

  localparam logic [3:0] LP_MAX_LEVEL = 4'(MAX_LEVEL);

  // FSM state doubles as the registered Opcode
  state_t                r_state;
  logic [1:0]            r_wr_gnt;
  logic [1:0]            r_rd_gnt;
  logic [DATA_WIDTH-1:0] r_din;
  logic [3:0]            r_level;
  logic                  r_wr_ptr;     // preferred writer on contention
  logic                  r_rd_ptr;     // preferred reader on contention
  logic                  r_last_write; // 1: last op was WRITE, 0: READ

  // Read return path
  logic [1:0]            r_tag2;       // reader id one cycle after RdGnt
  logic [1:0]            r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_wr_elig;
  logic                  w_rd_elig;
  state_t                w_next;
  logic                  w_wr_idx;
  logic                  w_rd_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;

  assign w_wr_elig = (|io_bus.WrReq) && (r_level < LP_MAX_LEVEL);
  assign w_rd_elig = (|io_bus.RdReq) && (r_level != 4'd0);

  // Round-robin pick: take the preferred requester if it asks, else the other one
  assign w_wr_idx  = io_bus.WrReq[r_wr_ptr] ? r_wr_ptr : ~r_wr_ptr;
  assign w_rd_idx  = io_bus.RdReq[r_rd_ptr] ? r_rd_ptr : ~r_rd_ptr;
  assign w_wr_data = w_wr_idx ? io_bus.WrData1 : io_bus.WrData0;

  // Choose the operation type; contention alternates against the last op
  always_comb begin
    w_next = ST_IDLE;
    if (w_wr_elig && w_rd_elig) begin
      w_next = r_last_write ? ST_READ : ST_WRITE;
    end else if (w_wr_elig) begin
      w_next = ST_WRITE;
    end else if (w_rd_elig) begin
      w_next = ST_READ;
    end else begin
      w_next = ST_IDLE;
    end
  end

  // Arbitration FSM with registered grants, FIFO command and shadow level
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_wr_gnt     <= 2'b00;
      r_rd_gnt     <= 2'b00;
      r_din        <= '0;
      r_level      <= 4'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_last_write <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_gnt <= 2'b00;
      r_rd_gnt <= 2'b00;
      case (w_next)
        ST_WRITE: begin
          r_wr_gnt     <= w_wr_idx ? 2'b10 : 2'b01;
          r_din        <= w_wr_data;
          r_level      <= r_level + 4'd1;
          r_wr_ptr     <= ~w_wr_idx;
          r_last_write <= 1'b1;
        end
        ST_READ: begin
          r_rd_gnt     <= w_rd_idx ? 2'b10 : 2'b01;
          r_level      <= r_level - 4'd1;
          r_rd_ptr     <= ~w_rd_idx;
          r_last_write <= 1'b0;
        end
        default: begin
          r_level <= r_level;
        end
      endcase
    end
  end

  // Carry the reader id alongside the FIFO read latency and capture FifoDout
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tag2     <= 2'b00;
      r_rd_valid <= 2'b00;
      r_rd_data  <= '0;
    end else begin
      r_tag2     <= r_rd_gnt;
      r_rd_valid <= r_tag2;
      if (|r_tag2) begin
        r_rd_data <= io_bus.FifoDout;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  assign io_bus.Opcode  = r_state;
  assign io_bus.WrGnt   = r_wr_gnt;
  assign io_bus.RdGnt   = r_rd_gnt;
  assign io_bus.Din     = r_din;
  assign io_bus.Level   = r_level;
  assign io_bus.RdValid = r_rd_valid;
  assign io_bus.RdData  = r_rd_data;

endmodule

// File: doc/fifo_access_arbiter.md
Name: fifo_access_arbiter

Overview:
- Shares one 16-entry x 32-bit FIFO between two write requesters and two read requesters.
- Drives the FIFO Opcode/Din pins with registered outputs and issues at most one operation per cycle.
- Keeps a shadow occupancy count, so it never relies on the late FifoFull/FifoEmpty flags.
- Routes returning FifoDout data to the reader that was granted.
- Sits between the client logic and the FIFO.

Parameters:
- DATA_WIDTH, 32, width of the data path to/from the FIFO.
- MAX_LEVEL, 15, highest occupancy allowed; matches the FIFO full threshold.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- WrReq  in  2  write request, one bit per writer; held high while the writer has data.
- WrData0  in  DATA_WIDTH  writer 0 data word.
- WrData1  in  DATA_WIDTH  writer 1 data word.
- WrGnt  out  2  one-cycle write grant, one-hot or zero.
- RdReq  in  2  read request, one bit per reader.
- RdGnt  out  2  one-cycle read grant, one-hot or zero.
- RdValid  out  2  read data valid for the matching reader.
- RdData  out  DATA_WIDTH  read data returned to the reader flagged by RdValid.
- Opcode  out  2  FIFO command: 01 write, 10 read, 00 idle.
- Din  out  DATA_WIDTH  FIFO write data.
- FifoDout  in  DATA_WIDTH  FIFO registered read data.
- Level  out  4  shadow occupancy, 0..MAX_LEVEL.

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. Every register updates only on the rising edge of Clk.
- Reset values: Opcode=00, Din=0, WrGnt=0, RdGnt=0, RdValid=0, RdData=0, Level=0. Both round-robin pointers point to requester 0. LastOp=READ, so the first contended cycle favours a write.
- FSM, held as the registered Opcode:
  - IDLE (00), WRITE (01), READ (10).
  - The next state is decided at every rising edge from the requests and Level sampled at that edge.
  - Any state can go to any state. Back-to-back WRITE or READ is allowed.
- Eligibility:
  - Write is eligible when |WrReq and Level < MAX_LEVEL.
  - Read is eligible when |RdReq and Level > 0.
- Op-type choice:
  - Only one type eligible: that type is chosen.
  - Both eligible: choose the type opposite LastOp, then update LastOp.
  - Neither eligible: IDLE.
- Requester choice within a type:
  - Round-robin. The pointer advances past the granted requester.
  - With a single requester, that requester is granted every cycle it is eligible.
- Handshake:
  - Requests and WrDataN are sampled at edge E.
  - For a granted write: WrGnt[n]=1, Opcode=01 and Din=WrDataN during cycle E..E+1.
  - The writer must present its next word, or drop WrReq, before edge E+1.
  - Grants last exactly one cycle per transfer.
- Read return:
  - Opcode=10 during cycle k, so the FIFO loads Dout at the end of cycle k.
  - The arbiter registers FifoDout at the end of cycle k+1.
  - RdValid[n]=1 with RdData in cycle k+2, for exactly one cycle.
  - A 2-stage tag pipeline carries the reader id. Back-to-back reads give back-to-back RdValid pulses in grant order.
  - RdData holds its last value when RdValid=0.
- Level:
  - +1 on a WRITE decision, -1 on a READ decision, held on IDLE.
  - Level never wraps: it stays in 0..MAX_LEVEL by construction.
  - Level is updated at the decision edge, so a read may be issued the cycle after a write to an empty FIFO.
- Full/empty boundaries:
  - At Level=MAX_LEVEL, writes stall with WrGnt=0 and no overflow reaches the FIFO.
  - At Level=0, reads stall and no underflow reaches the FIFO.
- Reset mid-operation: in-flight read tags are discarded and no RdValid is produced after reset. The FIFO must share the same Reset.
- Requests asserted during reset are ignored. Arbitration starts at the first edge with Reset=0.

Test Plan:
- Single write then read: reset, then WrReq=01 with WrData0=32'hA5A5_0001 for one word, then RdReq=10.
  - Required: Opcode=01 and Din=A5A5_0001 one cycle after the request; Level=1.
  - Required: RdGnt=10, then RdValid=10 two cycles later with RdData=A5A5_0001; Level=0.
- Write fairness: both writers held high, Level=0, 8 cycles.
  - Required: WrGnt alternates 01,10,01,10..., with no IDLE cycles; Level reaches 8.
- Full stall: fill to Level=15, keep WrReq=11 and raise RdReq=01.
  - Required: no write is granted while Level=15.
  - Required: read and write then alternate, with Level toggling 14/15; no Opcode=01 is issued at Level=15.
- Empty stall: RdReq=11 with Level=0 for 5 cycles.
  - Required: Opcode=00, RdGnt=0, RdValid=0 throughout.
- Read ordering: preload words 1..4, RdReq=11 held.
  - Required: RdGnt=01,10,01,10 and RdValid=01,10,01,10 two cycles later, with RdData=1,2,3,4 in order.
- Reset mid-read: assert Reset in the cycle after RdGnt.
  - Required: no RdValid in the following 3 cycles; all outputs at their reset values; Level=0.
